// File: rtl/xm23_clock_ctrl.sv
// XM23 clock and run control: programmable clock divider with HALT/RUN/STEP
// sequencing, sleep-driven halting, heartbeat LED and tick counter.
module xm23_clock_ctrl #(
  parameter int unsigned DIV_W     = 32,
  parameter int unsigned DIV_RESET = 1,
  parameter bit          START_RUN = 1'b1,
  parameter int unsigned LED_DIV   = 8,
  parameter int unsigned CYC_W     = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             led,
  output logic [1:0]       state,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned LED_W = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_INIT = (DIV_RESET == 0) ? DIV_W'(1) : DIV_W'(DIV_RESET);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_DIV - 1);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam state_t STATE_INIT = START_RUN ? RUN : HALT;

  state_t           st;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_pend;
  logic             pend_v;
  logic             step_q;
  logic [LED_W-1:0] led_cnt;

  logic active;
  logic boundary;
  logic step_rise;

  assign active    = (st == RUN) || (st == STEP);
  assign boundary  = active && (cnt == div - DIV_W'(1));
  assign step_rise = step & ~step_q;
  assign state     = st;

  // Divider, run-control FSM and counters; halting only ever happens on a
  // falling boundary, so clk_out is guaranteed low in HALT.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      st          <= STATE_INIT;
      cnt         <= '0;
      div         <= DIV_INIT;
      div_pend    <= DIV_INIT;
      pend_v      <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      step_q      <= 1'b1;
      led_cnt     <= '0;
      led         <= 1'b0;
      cycle_count <= '0;
    end else begin
      step_q <= step;
      tick   <= boundary && !clk_out;

      if (boundary) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
      end else if (active) begin
        cnt <= cnt + DIV_W'(1);
      end else begin
        cnt <= '0;
      end

      if (boundary && !clk_out) begin
        cycle_count <= cycle_count + CYC_W'(1);
        if (led_cnt == LED_LAST) begin
          led_cnt <= '0;
          led     <= ~led;
        end else begin
          led_cnt <= led_cnt + LED_W'(1);
        end
      end

      // A new write in the same cycle as an application re-arms the pending slot.
      if (pend_v && (boundary || st == HALT)) begin
        div    <= div_pend;
        pend_v <= 1'b0;
      end
      if (div_wr) begin
        div_pend <= (div_val == '0) ? DIV_W'(1) : div_val;
        pend_v   <= 1'b1;
      end

      case (st)
        HALT: begin
          if (run && !halt_req) st <= RUN;
          else if (step_rise)   st <= STEP;
        end
        RUN: begin
          if (boundary && clk_out && (!run || halt_req)) st <= HALT;
        end
        STEP: begin
          if (boundary && clk_out) st <= HALT;
        end
        default: st <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_xm23_clock_ctrl.sv
// Self-checking bench for xm23_clock_ctrl: directed scenarios plus a random
// run against a half-period based reference model.
module tb_xm23_clock_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic        halt_req;
  logic        div_wr;
  logic [31:0] div_val;
  logic        clk_out;
  logic        tick;
  logic        led;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  xm23_clock_ctrl #(
    .DIV_W(32), .DIV_RESET(1), .START_RUN(1'b1), .LED_DIV(8), .CYC_W(32)
  ) dut (
    .clk_in(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .div_wr(div_wr), .div_val(div_val), .clk_out(clk_out), .tick(tick),
    .led(led), .state(state), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks position inside the current half-period and the
  // total number of ticks; led and cycle_count are derived from that total.
  int              m_state;
  int unsigned     m_half;
  bit              m_hi;
  int unsigned     m_div;
  int unsigned     m_pend;
  bit              m_pv;
  bit              m_tick;
  longint unsigned m_ticks;
  bit              m_step_prev;
  bit              m_act;
  bit              m_end;
  bit              m_rise;
  bit              m_apply;

  always @(posedge clk) begin
    if (reset) begin
      m_state = 1; m_half = 0; m_hi = 0; m_div = 1; m_pend = 1; m_pv = 0;
      m_tick = 0; m_ticks = 0; m_step_prev = 1;
    end else begin
      m_act   = (m_state != 0);
      m_end   = m_act && (m_half + 1 == m_div);
      m_rise  = step && !m_step_prev;
      m_apply = m_pv && (m_end || m_state == 0);
      m_tick  = m_end && !m_hi;
      if (m_tick) m_ticks++;
      if (m_state == 0) begin
        if (run && !halt_req) m_state = 1;
        else if (m_rise)      m_state = 2;
      end else if (m_end && m_hi && (m_state == 2 || !run || halt_req)) begin
        m_state = 0;
      end
      if (m_end) begin
        m_hi = !m_hi;
        m_half = 0;
      end else if (m_act) begin
        m_half++;
      end else begin
        m_half = 0;
      end
      if (m_apply) begin
        m_div = m_pend;
        m_pv = 0;
      end
      if (div_wr) begin
        m_pend = (div_val == 0) ? 1 : div_val;
        m_pv = 1;
      end
      m_step_prev = step;
    end
  end

  task automatic test_reset();
    reset = 1; run = 1; step = 0; halt_req = 0; div_wr = 0; div_val = 0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd1)       begin errors++; $display("FAIL reset_state: got %0d expected 1", state); end
    checks++; if (clk_out !== 1'b0)     begin errors++; $display("FAIL reset_clk_out: got %0b expected 0", clk_out); end
    checks++; if (tick !== 1'b0)        begin errors++; $display("FAIL reset_tick: got %0b expected 0", tick); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    checks++; if (led !== 1'b0)         begin errors++; $display("FAIL reset_led: got %0b expected 0", led); end
  endtask

  task automatic test_reset_run();
    reset = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++; if (clk_out !== 1'((i % 2) == 1)) begin errors++; $display("FAIL run_clk_out[%0d]: got %0b expected %0b", i, clk_out, (i % 2) == 1); end
      checks++; if (tick !== 1'((i % 2) == 1))    begin errors++; $display("FAIL run_tick[%0d]: got %0b expected %0b", i, tick, (i % 2) == 1); end
      if (i == 14) begin
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL run_led_before: got %0b expected 0", led); end
      end
    end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL run_cycle_count: got %0d expected 10", cycle_count); end
    checks++; if (led !== 1'b1)           begin errors++; $display("FAIL run_led_after: got %0b expected 1", led); end
  endtask

  task automatic test_stop_restart();
    div_wr = 1; div_val = 3;
    @(negedge clk);
    div_wr = 0;
    checks++; if (clk_out !== 1'b1) begin errors++; $display("FAIL stop_mid_high: got %0b expected 1", clk_out); end
    run = 0;
    @(negedge clk);
    checks++; if (state !== 2'd0)   begin errors++; $display("FAIL stop_state: got %0d expected 0", state); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL stop_clk_out: got %0b expected 0", clk_out); end
    run = 1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_state: got %0d expected 1", state); end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++; if (clk_out !== 1'((i >= 3 && i < 6) || i >= 9)) begin errors++; $display("FAIL restart_clk_out[%0d]: got %0b", i, clk_out); end
      checks++; if (tick !== 1'(i == 3 || i == 9))               begin errors++; $display("FAIL restart_tick[%0d]: got %0b", i, tick); end
    end
  endtask

  task automatic test_single_step();
    int n;
    int ticks;
    logic [31:0] cc0;
    run = 0;
    n = 0;
    while (state !== 2'd0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL step_halt_timeout: got %0d expected 0", state); end
    div_wr = 1; div_val = 4;
    @(negedge clk);
    div_wr = 0;
    @(negedge clk);
    cc0 = cycle_count;
    ticks = 0;
    step = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      checks++; if (state !== ((i <= 8) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL step_state[%0d]: got %0d expected %0d", i, state, (i <= 8) ? 2 : 0); end
    end
    checks++; if (ticks != 1)              begin errors++; $display("FAIL step_ticks: got %0d expected 1", ticks); end
    checks++; if (cycle_count !== cc0 + 1) begin errors++; $display("FAIL step_cycle_count: got %0d expected %0d", cycle_count, cc0 + 1); end
    step = 0;
    @(negedge clk);
    // Step held high across reset must not register as an edge.
    step = 1; reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL step_through_reset[%0d]: got %0d expected 0", i, state); end
      @(negedge clk);
    end
    step = 0;
  endtask

  task automatic test_sleep_halt();
    int n;
    int ticks;
    run = 1; halt_req = 0;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL sleep_run: got %0d expected 1", state); end
    halt_req = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (state !== 2'd0 && n < 10);
    checks++; if (n > 2)            begin errors++; $display("FAIL sleep_latency: got %0d expected <=2", n); end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL sleep_clk_out: got %0b expected 0", clk_out); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL sleep_hold[%0d]: got %0d expected 0", i, state); end
    end
    step = 1;
    @(negedge clk);
    step = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL sleep_step_enter: got %0d expected 2", state); end
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    checks++; if (ticks != 1)     begin errors++; $display("FAIL sleep_step_ticks: got %0d expected 1", ticks); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL sleep_step_exit: got %0d expected 0", state); end
    halt_req = 0;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL sleep_wake: got %0d expected 1", state); end
  endtask

  task automatic test_div_edges();
    int n;
    int ticks;
    div_wr = 1; div_val = 0;
    @(negedge clk);
    div_wr = 0;
    repeat (2) @(negedge clk);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    checks++; if (ticks != 5) begin errors++; $display("FAIL div_zero_ticks: got %0d expected 5", ticks); end
    div_wr = 1; div_val = 3;
    @(negedge clk);
    div_wr = 0;
    repeat (8) @(negedge clk);
    n = 0;
    while (!tick && n < 20) begin @(negedge clk); n++; end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL div_wait_tick: got %0b expected 1", tick); end
    div_wr = 1; div_val = 5;
    @(negedge clk);
    div_val = 7;
    @(negedge clk);
    div_wr = 0;
    n = 2;
    do begin @(negedge clk); n++; end while (!tick && n < 40);
    checks++; if (n != 10) begin errors++; $display("FAIL div_last_write_first: got %0d expected 10", n); end
    n = 0;
    do begin @(negedge clk); n++; end while (!tick && n < 40);
    checks++; if (n != 14) begin errors++; $display("FAIL div_last_write_period: got %0d expected 14", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    run = 0;
    n = 0;
    while (state !== 2'd0 && n < 40) begin @(negedge clk); n++; end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_halt_timeout: got %0d expected 0", state); end
    step = 1;
    @(negedge clk);
    step = 0;
    n = 0;
    while (!(clk_out === 1'b1 && state === 2'd2) && n < 30) begin @(negedge clk); n++; end
    checks++; if (clk_out !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL mid_step_high: got state %0d clk_out %0b expected 2/1", state, clk_out); end
    reset = 1;
    @(negedge clk);
    checks++; if (clk_out !== 1'b0)      begin errors++; $display("FAIL mid_clk_out: got %0b expected 0", clk_out); end
    checks++; if (tick !== 1'b0)         begin errors++; $display("FAIL mid_tick: got %0b expected 0", tick); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL mid_cycle_count: got %0d expected 0", cycle_count); end
    checks++; if (state !== 2'd1)        begin errors++; $display("FAIL mid_state: got %0d expected 1", state); end
    reset = 0;
  endtask

  task automatic test_random();
    logic        exp_led;
    logic [31:0] exp_cc;
    run = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      exp_led = 1'(((m_ticks / 8) % 2) == 1);
      exp_cc  = 32'(m_ticks);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, state, m_state); end
      checks++; if (clk_out !== m_hi)      begin errors++; $display("FAIL rnd_clk_out[%0d]: got %0b expected %0b", i, clk_out, m_hi); end
      checks++; if (tick !== m_tick)       begin errors++; $display("FAIL rnd_tick[%0d]: got %0b expected %0b", i, tick, m_tick); end
      checks++; if (cycle_count !== exp_cc) begin errors++; $display("FAIL rnd_cycle_count[%0d]: got %0d expected %0d", i, cycle_count, exp_cc); end
      checks++; if (led !== exp_led)       begin errors++; $display("FAIL rnd_led[%0d]: got %0b expected %0b", i, led, exp_led); end
      if ($urandom_range(0, 29) == 0) run = ~run;
      if ($urandom_range(0, 39) == 0) halt_req = ~halt_req;
      step    = ($urandom_range(0, 5) == 0);
      div_wr  = ($urandom_range(0, 24) == 0);
      div_val = $urandom_range(0, 4);
      reset   = ($urandom_range(0, 399) == 0);
    end
    reset = 0; div_wr = 0; step = 0; halt_req = 0;
  endtask

  initial begin
    test_reset();
    test_reset_run();
    test_stop_restart();
    test_single_step();
    test_sleep_halt();
    test_div_edges();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
